dual_issue_controller: RTL and testbench

DUAL_ISSUE_CONTROLLER -- requirements
Module: dual_issue_controller

---
 rtl/issue_pkg.sv | 40 ++++
 rtl/issue_hazard_check.sv | 41 ++++
 rtl/dual_issue_controller.sv | 140 ++++++++++++++
 tb/tb_dual_issue_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and decode helpers for the dual-issue controller:
// FSM state encoding, opcode constants and instruction field slices.
package issue_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int REG_W   = 5;

  function automatic logic [REG_W-1:0] field_rd(input logic [31:0] ins);
    return ins[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] field_rs1(input logic [31:0] ins);
    return ins[RS1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] field_rs2(input logic [31:0] ins);
    return ins[RS2_LSB +: REG_W];
  endfunction

  // Stores and branches carry immediate bits in the rd field, so they never write.
  function automatic logic writes_rd(input logic [31:0] ins);
    logic [OPC_W-1:0] opc;
    opc = ins[OPC_LSB +: OPC_W];
    return (ins != 32'd0) && (opc != STORE) && (opc != BRANCH);
  endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational hazard screen for an in-order instruction pair against
// the scoreboard (issue0_ok) and against each other (issue1_ok).
module issue_hazard_check
  import issue_pkg::*;
(
  input  logic [31:0] instruction0,
  input  logic [31:0] instruction1,
  input  logic [31:0] sb_busy,
  output logic        issue0_ok,
  output logic        issue1_ok
);

  function automatic logic sb_hit(input logic [31:0] sb, input logic [REG_W-1:0] r);
    return (r != '0) && sb[r];
  endfunction

  logic [REG_W-1:0] rd0, rs1_0, rs2_0;
  logic [REG_W-1:0] rd1, rs1_1, rs2_1;
  logic             wr0, wr1;
  logic             hit0, hit1, raw, waw;

  always_comb begin
    rd0   = field_rd(instruction0);
    rs1_0 = field_rs1(instruction0);
    rs2_0 = field_rs2(instruction0);
    rd1   = field_rd(instruction1);
    rs1_1 = field_rs1(instruction1);
    rs2_1 = field_rs2(instruction1);
    wr0   = writes_rd(instruction0);
    wr1   = writes_rd(instruction1);

    hit0 = sb_hit(sb_busy, rs1_0) || sb_hit(sb_busy, rs2_0) || sb_hit(sb_busy, rd0);
    hit1 = sb_hit(sb_busy, rs1_1) || sb_hit(sb_busy, rs2_1) || sb_hit(sb_busy, rd1);
    raw  = wr0 && (rd0 != '0) && ((rs1_1 == rd0) || (rs2_1 == rd0));
    waw  = wr0 && wr1 && (rd0 != '0) && (rd1 == rd0);

    issue0_ok = !hit0;
    issue1_ok = !hit1 && !raw && !waw;
  end

endmodule

// File: rtl/dual_issue_controller.sv
// In-order dual-issue controller with register scoreboard and flush/drain FSM.
// Define ISSUE_PERF_EN to add saturating dual/single/stall cycle counters.
module dual_issue_controller
  import issue_pkg::*;
#(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction0,
  input  logic [31:0]       instruction1,
  input  logic              ins0_valid,
  input  logic              ins1_valid,
  output logic [1:0]        consume,
  output logic              dp1_en,
  output logic              dp2_en,
  input  logic              dp1_done,
  input  logic              dp2_done,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [31:0]       sb_busy
`ifdef ISSUE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_dual,
  output logic [PERF_W-1:0] perf_single,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  state_t           state_q, state_d;
  logic             dp1_busy_q, dp2_busy_q;
  logic [REG_W-1:0] dp1_rd_q, dp2_rd_q;
  logic [31:0]      sb_q;

  logic             dp1_clr, dp2_clr, dp1_idle, dp2_idle;
  logic [31:0]      clr_mask, set_mask, sb_eff, sb_next;
  logic [REG_W-1:0] rd0_w, rd1_w;
  logic             issue0_ok, issue1_ok, run, issue0, issue1, bubble0;

  assign sb_busy = sb_q;

  // A done pulse frees its datapath and scoreboard bit within the same cycle,
  // so a dependent instruction may issue alongside the completion.
  always_comb begin
    dp1_clr  = dp1_done && dp1_busy_q;
    dp2_clr  = dp2_done && dp2_busy_q;
    dp1_idle = !dp1_busy_q || dp1_clr;
    dp2_idle = !dp2_busy_q || dp2_clr;
    clr_mask = '0;
    if (dp1_clr) clr_mask[dp1_rd_q] = 1'b1;
    if (dp2_clr) clr_mask[dp2_rd_q] = 1'b1;
    sb_eff   = sb_q & ~clr_mask;
  end

  issue_hazard_check u_hazard (
    .instruction0 (instruction0),
    .instruction1 (instruction1),
    .sb_busy      (sb_eff),
    .issue0_ok    (issue0_ok),
    .issue1_ok    (issue1_ok)
  );

  // Issue decision; a bubble in slot 0 is retired alone so slot 1 moves to datapath 1.
  always_comb begin
    run     = (state_q == RUN) && !rst;
    bubble0 = ins0_valid && (instruction0 == 32'd0);
    issue0  = run && ins0_valid && (instruction0 != 32'd0) && dp1_idle && issue0_ok;
    issue1  = issue0 && ins1_valid && (instruction1 != 32'd0) && dp2_idle && issue1_ok;
    dp1_en  = issue0;
    dp2_en  = issue1;
    if (issue1) begin
      consume = 2'd2;
    end else if (issue0 || (run && bubble0)) begin
      consume = 2'd1;
    end else begin
      consume = 2'd0;
    end

    rd0_w    = writes_rd(instruction0) ? field_rd(instruction0) : '0;
    rd1_w    = writes_rd(instruction1) ? field_rd(instruction1) : '0;
    set_mask = '0;
    if (issue0) set_mask[rd0_w] = 1'b1;
    if (issue1) set_mask[rd1_w] = 1'b1;
    sb_next  = (sb_eff | set_mask) & ~32'd1;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!dp1_busy_q && !dp2_busy_q && (sb_q == '0)) state_d = DONE;
      end
      DONE: begin
        flush_done = !rst;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      dp1_busy_q <= 1'b0;
      dp2_busy_q <= 1'b0;
      dp1_rd_q   <= '0;
      dp2_rd_q   <= '0;
      sb_q       <= '0;
    end else begin
      state_q    <= state_d;
      sb_q       <= sb_next;
      dp1_busy_q <= issue0 || (dp1_busy_q && !dp1_clr);
      dp2_busy_q <= issue1 || (dp2_busy_q && !dp2_clr);
      if (issue0) dp1_rd_q <= rd0_w;
      if (issue1) dp2_rd_q <= rd1_w;
    end
  end

`ifdef ISSUE_PERF_EN
  // Only cycles with work offered in RUN are classified; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dual   <= '0;
      perf_single <= '0;
      perf_stall  <= '0;
    end else if ((state_q == RUN) && ins0_valid) begin
      case (consume)
        2'd2:    if (perf_dual   != '1) perf_dual   <= perf_dual   + 1'b1;
        2'd1:    if (perf_single != '1) perf_single <= perf_single + 1'b1;
        default: if (perf_stall  != '1) perf_stall  <= perf_stall  + 1'b1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_controller.sv
// Directed self-checking bench for dual_issue_controller; the perf counter
// scenario runs only when ISSUE_PERF_EN is defined.
module tb_dual_issue_controller;

`ifdef ISSUE_PERF_EN
  localparam int TB_PERF_W = 4;
`else
  localparam int TB_PERF_W = 16;
`endif

  localparam logic [31:0] ADDI_X1_1  = 32'h00100093;
  localparam logic [31:0] ADDI_X2_2  = 32'h00200113;
  localparam logic [31:0] ADDI_X1_3  = 32'h00300093;
  localparam logic [31:0] ADDI_X3_5  = 32'h00500193;
  localparam logic [31:0] ADD_X4_X3  = 32'h00318233;
  localparam logic [31:0] ADDI_X5_1  = 32'h00100293;
  localparam logic [31:0] ADDI_X6_1  = 32'h00100313;
  localparam logic [31:0] ADDI_X7_1  = 32'h00100393;
  localparam logic [31:0] ADDI_X8_8  = 32'h00800413;
  localparam logic [31:0] ADDI_X9_1  = 32'h00100493;
  localparam logic [31:0] SW_X0_12   = 32'h00002623;
  localparam logic [31:0] ADDI_X13_X12 = 32'h00160693;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction0, instruction1;
  logic        ins0_valid, ins1_valid;
  logic [1:0]  consume;
  logic        dp1_en, dp2_en, dp1_done, dp2_done, flush_req, flush_done;
  logic [31:0] sb_busy;
`ifdef ISSUE_PERF_EN
  logic [TB_PERF_W-1:0] perf_dual, perf_single, perf_stall;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  dual_issue_controller #(.PERF_W(TB_PERF_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction0 (instruction0),
    .instruction1 (instruction1),
    .ins0_valid   (ins0_valid),
    .ins1_valid   (ins1_valid),
    .consume      (consume),
    .dp1_en       (dp1_en),
    .dp2_en       (dp2_en),
    .dp1_done     (dp1_done),
    .dp2_done     (dp2_done),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .sb_busy      (sb_busy)
`ifdef ISSUE_PERF_EN
    ,
    .perf_dual    (perf_dual),
    .perf_single  (perf_single),
    .perf_stall   (perf_stall)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i0, input logic [31:0] i1, input logic v0,
                               input logic v1, input logic d1, input logic d2, input logic fl);
    instruction0 = i0;
    instruction1 = i1;
    ins0_valid   = v0;
    ins1_valid   = v1;
    dp1_done     = d1;
    dp2_done     = d2;
    flush_req    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic checkIssue(input string tag, input logic e1, input logic e2, input logic [1:0] c);
    checkOutput({tag, "_dp1_en"}, {31'd0, dp1_en}, {31'd0, e1});
    checkOutput({tag, "_dp2_en"}, {31'd0, dp2_en}, {31'd0, e2});
    checkOutput({tag, "_consume"}, {30'd0, consume}, {30'd0, c});
  endtask

  initial begin
    // Reset holds issue off even with a ready pair presented.
    rst = 1'b1;
    applyStimulus(ADDI_X1_1, ADDI_X2_2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkIssue("in_reset", 1'b0, 1'b0, 2'd0);
    tick();
    checkOutput("reset_sb", sb_busy, 32'h0);
    checkOutput("reset_flush_done", {31'd0, flush_done}, 32'd0);

    // Independent pair dual-issues, then datapath 1 busy blocks the next op.
    rst = 1'b0;
    applyStimulus(ADDI_X1_1, ADDI_X2_2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkIssue("indep", 1'b1, 1'b1, 2'd2);
    tick();
    applyStimulus(ADDI_X8_8, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("indep_sb", sb_busy, 32'h0000_0006);
    checkIssue("dp1_busy", 1'b0, 1'b0, 2'd0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("indep_clear_sb", sb_busy, 32'h0);

    // RAW pair: only the producer goes, consumer waits for its completion.
    applyReset();
    applyStimulus(ADDI_X3_5, ADD_X4_X3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkIssue("raw", 1'b1, 1'b0, 2'd1);
    tick();
    applyStimulus(ADD_X4_X3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("raw_sb", sb_busy, 32'h0000_0008);
    checkIssue("raw_stall1", 1'b0, 1'b0, 2'd0);
    tick();
    checkIssue("raw_stall2", 1'b0, 1'b0, 2'd0);
    applyStimulus(ADD_X4_X3, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkIssue("raw_release", 1'b1, 1'b0, 2'd1);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("raw_release_sb", sb_busy, 32'h0000_0010);

    // Bubble in slot 0 retires alone; the follower issues next cycle on dp1.
    applyReset();
    applyStimulus(32'd0, ADDI_X5_1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkIssue("bubble", 1'b0, 1'b0, 2'd1);
    tick();
    checkOutput("bubble_sb", sb_busy, 32'h0);
    applyStimulus(ADDI_X5_1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkIssue("after_bubble", 1'b1, 1'b0, 2'd1);
    tick();
    checkOutput("after_bubble_sb", sb_busy, 32'h0000_0020);

    // WAW pair and a bubble in slot 1 both limit the cycle to one issue.
    applyReset();
    applyStimulus(ADDI_X1_1, ADDI_X1_3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkIssue("waw", 1'b1, 1'b0, 2'd1);
    applyStimulus(ADDI_X1_1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkIssue("bubble_slot1", 1'b1, 1'b0, 2'd1);

    // A store writes nothing, so a reader of its rd-field register is not a RAW.
    applyReset();
    applyStimulus(SW_X0_12, ADDI_X13_X12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkIssue("store_pair", 1'b1, 1'b1, 2'd2);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("store_pair_sb", sb_busy, 32'h0000_2000);

    // Flush: issue x7, drain, completion, one-cycle flush_done, back to RUN.
    applyReset();
    applyStimulus(ADDI_X7_1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkIssue("flush_issue", 1'b1, 1'b0, 2'd1);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_sb", sb_busy, 32'h0000_0080);
    tick();
    applyStimulus(ADDI_X9_1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkIssue("drain_done_cycle", 1'b0, 1'b0, 2'd0);
    checkOutput("drain_flush_done0", {31'd0, flush_done}, 32'd0);
    tick();
    applyStimulus(ADDI_X9_1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_sb_clear", sb_busy, 32'h0);
    checkIssue("drain_idle", 1'b0, 1'b0, 2'd0);
    checkOutput("drain_flush_done1", {31'd0, flush_done}, 32'd0);
    tick();
    checkOutput("done_flush_done", {31'd0, flush_done}, 32'd1);
    checkIssue("done_state", 1'b0, 1'b0, 2'd0);
    tick();
    checkOutput("run_flush_done", {31'd0, flush_done}, 32'd0);
    checkIssue("run_again", 1'b1, 1'b0, 2'd1);

    // Same-cycle clear and set of x6: set wins; a plain clear then frees it.
    applyReset();
    applyStimulus(ADDI_X6_1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(ADDI_X6_1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkIssue("x6_reissue", 1'b1, 1'b0, 2'd1);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("x6_set_wins", sb_busy, 32'h0000_0040);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("x6_cleared", sb_busy, 32'h0);

    // Reset with an op in flight discards it; a late done is harmless.
    applyStimulus(ADDI_X7_1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyReset();
    checkOutput("midflight_reset_sb", sb_busy, 32'h0);
    applyStimulus(ADDI_X8_8, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkIssue("late_done", 1'b1, 1'b0, 2'd1);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("late_done_sb", sb_busy, 32'h0000_0100);

`ifdef ISSUE_PERF_EN
    // Twenty dual-issue cycles saturate a 4-bit counter at 15.
    applyReset();
    checkOutput("perf_reset_dual", {28'd0, perf_dual}, 32'd0);
    applyStimulus(ADDI_X1_1, ADDI_X2_2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    checkOutput("perf_dual_sat", {28'd0, perf_dual}, 32'd15);
    checkOutput("perf_single", {28'd0, perf_single}, 32'd0);
    checkOutput("perf_stall", {28'd0, perf_stall}, 32'd0);
    applyReset();
    checkOutput("perf_rst_dual", {28'd0, perf_dual}, 32'd0);
    checkOutput("perf_rst_single", {28'd0, perf_single}, 32'd0);
    checkOutput("perf_rst_stall", {28'd0, perf_stall}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
